// File: rtl/darksocv_uart_tx_arb.sv
// rtl/darksocv_uart_tx_arb.sv - round-robin arbiter sharing one 8N1 UART transmitter among NREQ byte sources
// Optional feature macro: UART_ARB_LINE_LOCK_EN (hold the grant on one source until it sends 0x0A).
module darksocv_uart_tx_arb #(
    parameter int NREQ     = 2,
    parameter int BAUD_DIV = 868,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              XCLK,
    input  logic              XRES,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              UART_TXD,
    output logic              busy,
    output logic [GW-1:0]     grant_id,
    output logic [3:0]        DEBUG
`ifdef UART_ARB_LINE_LOCK_EN
    ,
    output logic              locked
`endif
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_cnt_nx;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] rr_ptr_nx;
    logic [GW-1:0] grant_nx;
    logic          tx_q;
    logic          tx_nx;
    logic          tick;
    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [GW-1:0] cand;
    logic [7:0]    win_byte;
    logic          handshake;
    int            scan_idx;
`ifdef UART_ARB_LINE_LOCK_EN
    logic          lock_q;
    logic          lock_nx;
`endif

    assign tick = (baud_cnt == CW'(BAUD_DIV - 1));

    // Winner search: first valid requester at or after the RR pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = 0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = (int'(rr_ptr) + k) % NREQ;
            cand     = GW'(scan_idx);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
`ifdef UART_ARB_LINE_LOCK_EN
        if (lock_q) begin
            win_found = req_valid[grant_id];
            win_idx   = grant_id;
        end
`endif
    end

    assign win_byte  = req_data[{win_idx, 3'b000} +: 8];
    assign handshake = (state == S_IDLE) && XRES && win_found;

    always_ff @(posedge XCLK) begin
        if (!XRES) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            rr_ptr   <= '0;
            grant_id <= '0;
            tx_q     <= 1'b1;
`ifdef UART_ARB_LINE_LOCK_EN
            lock_q   <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_cnt_nx;
            bit_cnt  <= bit_cnt_nx;
            shreg    <= shreg_nx;
            rr_ptr   <= rr_ptr_nx;
            grant_id <= grant_nx;
            tx_q     <= tx_nx;
`ifdef UART_ARB_LINE_LOCK_EN
            lock_q   <= lock_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (handshake) state_nx = S_START;
            S_START: if (tick) state_nx = S_DATA;
            S_DATA:  if (tick && (bit_cnt == 3'd7)) state_nx = S_STOP;
            S_STOP:  if (tick) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs and datapath next values; TXD is registered from the next state.
    always_comb begin
        req_ready   = '0;
        baud_cnt_nx = '0;
        bit_cnt_nx  = '0;
        shreg_nx    = shreg;
        rr_ptr_nx   = rr_ptr;
        grant_nx    = grant_id;
        tx_nx       = 1'b1;
`ifdef UART_ARB_LINE_LOCK_EN
        lock_nx     = lock_q;
`endif
        if (handshake) begin
            req_ready[win_idx] = 1'b1;
            shreg_nx           = win_byte;
            grant_nx           = win_idx;
            rr_ptr_nx          = GW'((int'(win_idx) + 1) % NREQ);
`ifdef UART_ARB_LINE_LOCK_EN
            lock_nx            = (win_byte != 8'h0A);
`endif
        end
        if (state != S_IDLE && !tick) begin
            baud_cnt_nx = baud_cnt + 1'b1;
        end
        if (state == S_DATA) begin
            bit_cnt_nx = tick ? bit_cnt + 3'd1 : bit_cnt;
            if (tick) begin
                shreg_nx = {1'b0, shreg[7:1]};
            end
        end
        case (state_nx)
            S_START: tx_nx = 1'b0;
            S_DATA:  tx_nx = shreg_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

    assign UART_TXD = tx_q;
    assign busy     = (state != S_IDLE);
`ifdef UART_ARB_LINE_LOCK_EN
    assign locked   = lock_q;
    assign DEBUG    = {busy, tx_q, state[1], lock_q};
`else
    assign DEBUG    = {busy, tx_q, state};
`endif

endmodule

// File: tb/tb_darksocv_uart_tx_arb.sv
// tb/tb_darksocv_uart_tx_arb.sv - directed scoreboard bench for darksocv_uart_tx_arb (two configurations)
module tb_darksocv_uart_tx_arb;

    logic        clk = 1'b0;
    logic        xres;
    logic [1:0]  valid_a;
    logic [15:0] data_a;
    logic [1:0]  ready_a;
    logic        txd_a;
    logic        busy_a;
    logic [0:0]  grant_a;
    logic [3:0]  debug_a;
    logic [3:0]  valid_b;
    logic [31:0] data_b;
    logic [3:0]  ready_b;
    logic        txd_b;
    logic        busy_b;
    logic [1:0]  grant_b;
    logic [3:0]  debug_b;
`ifdef UART_ARB_LINE_LOCK_EN
    logic        locked_a;
    logic        locked_b;
`endif

    int total = 0;
    int bad   = 0;
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    darksocv_uart_tx_arb #(.NREQ(2), .BAUD_DIV(4)) u_a (
        .XCLK(clk), .XRES(xres), .req_valid(valid_a), .req_data(data_a),
        .req_ready(ready_a), .UART_TXD(txd_a), .busy(busy_a),
        .grant_id(grant_a), .DEBUG(debug_a)
`ifdef UART_ARB_LINE_LOCK_EN
        , .locked(locked_a)
`endif
    );

    darksocv_uart_tx_arb #(.NREQ(4), .BAUD_DIV(1)) u_b (
        .XCLK(clk), .XRES(xres), .req_valid(valid_b), .req_data(data_b),
        .req_ready(ready_b), .UART_TXD(txd_b), .busy(busy_b),
        .grant_id(grant_b), .DEBUG(debug_b)
`ifdef UART_ARB_LINE_LOCK_EN
        , .locked(locked_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serial decoder for u_a: pops the scoreboard at each stop bit.
    int         mon_cnt = 0;
    bit         mon_on  = 0;
    logic [7:0] mon_byte;
    logic [8:0] exp_item;
    always @(negedge clk) begin
        if (!xres) begin
            mon_on = 0;
        end else if (!mon_on) begin
            if (txd_a === 1'b0) begin
                mon_on  = 1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) check("mon_start_bit", txd_a, 1'b0);
            if (mon_cnt >= 4 && mon_cnt <= 32 && (mon_cnt % 4) == 0)
                mon_byte[mon_cnt / 4 - 1] = txd_a;
            if (mon_cnt == 36) begin
                check("mon_stop_bit", txd_a, 1'b1);
                check("mon_sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    exp_item = sb.pop_front();
                    check("mon_id_byte", {grant_a, mon_byte}, exp_item);
                end
                mon_on = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk) xres = 1'b0;
        @(negedge clk);
        @(negedge clk) xres = 1'b1;
    endtask

    task automatic send_a(input int id, input logic [7:0] d);
        int n = 0;
        data_a[id*8 +: 8] = d;
        valid_a = 2'b00;
        valid_a[id] = 1'b1;
        #1;
        while (ready_a[id] !== 1'b1 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("send_ready_bound", n < 500, 1'b1);
        sb.push_back({id[0], d});
        @(negedge clk) valid_a = 2'b00;
    endtask

    task automatic wait_idle_a(input string tag);
        int n = 0;
        while ((busy_a !== 1'b0 || sb.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"}, n < 3000, 1'b1);
    endtask

    initial begin
        logic [39:0] obs40;
        logic [39:0] exp40;
        logic [9:0]  obs10;
        logic [7:0]  byte_v;
        int          busy_cnt;
        int          ids[4];
        int          cyc[4];
        int          n;
        int          c;
        int          low_cnt;
        int          rdy_cnt;

        xres    = 1'b0;
        valid_a = '0;
        data_a  = '0;
        valid_b = '0;
        data_b  = '0;
        repeat (3) @(negedge clk);
        valid_a = 2'b01;
        #1;
        check("rst_txd", txd_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_grant", grant_a, 1'b0);
        check("rst_ready", ready_a, 2'b00);
        check("rst_debug", debug_a, 4'b0100);
        valid_a = 2'b00;
        @(negedge clk) xres = 1'b1;

        // Single byte 0x55 from requester 0
        @(negedge clk);
        byte_v = 8'h55;
        data_a[7:0] = byte_v;
        valid_a = 2'b01;
        #1 check("t1_ready", ready_a, 2'b01);
        sb.push_back({1'b0, byte_v});
        @(negedge clk) valid_a = 2'b00;
        check("t1_ready_drop", ready_a, 2'b00);
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            obs40[i] = txd_a;
            exp40[i] = (i < 4) ? 1'b0 : (i >= 36) ? 1'b1 : byte_v[(i - 4) / 4];
            if (busy_a) busy_cnt++;
            @(negedge clk);
        end
        check("t1_waveform", obs40, exp40);
        check("t1_busy_cycles", busy_cnt, 40);
        check("t1_busy_end", busy_a, 1'b0);
        check("t1_grant", grant_a, 1'b0);
        wait_idle_a("t1");

        // Contention with both requesters continuously valid
        do_reset();
        data_a = {8'hB1, 8'hA0};
        valid_a = 2'b11;
        n = 0;
        c = 0;
        while (n < 4 && c < 400) begin
            #1;
            if (|(valid_a & ready_a)) begin
                ids[n] = ready_a[1] ? 1 : 0;
                cyc[n] = c;
                sb.push_back(ready_a[1] ? {1'b1, 8'hB1} : {1'b0, 8'hA0});
                n++;
            end
            if (n < 4) begin
                @(negedge clk);
                c++;
            end
        end
        @(negedge clk) valid_a = 2'b00;
        check("t2_count", n, 4);
        for (int i = 0; i < 4; i++) check("t2_order", ids[i], i % 2);
        for (int i = 1; i < 4; i++) check("t2_spacing", cyc[i] - cyc[i-1], 41);
        wait_idle_a("t2");

        // Reset in the middle of DATA bit 3
        do_reset();
        @(negedge clk);
        send_a(1, 8'h3C);
        repeat (17) @(negedge clk);
        xres = 1'b0;
        valid_a = 2'b01;
        data_a[7:0] = 8'h96;
        @(negedge clk);
        #1;
        check("t3_txd", txd_a, 1'b1);
        check("t3_busy", busy_a, 1'b0);
        check("t3_grant", grant_a, 1'b0);
        check("t3_ready", ready_a, 2'b00);
        sb.delete();
        @(negedge clk) xres = 1'b1;
        #1 check("t3_ready_after", ready_a, 2'b01);
        sb.push_back({1'b0, 8'h96});
        @(negedge clk) valid_a = 2'b00;
        check("t3_fresh_start", txd_a, 1'b0);
        wait_idle_a("t3");

        // Valid withdrawn while busy
        send_a(0, 8'h0F);
        repeat (10) @(negedge clk);
        valid_a = 2'b10;
        data_a[15:8] = 8'hEE;
        #1 check("t5_ready_busy", ready_a, 2'b00);
        @(negedge clk) valid_a = 2'b00;
        wait_idle_a("t5");
        low_cnt = 0;
        rdy_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (txd_a !== 1'b1) low_cnt++;
            if (ready_a !== 2'b00) rdy_cnt++;
        end
        check("t5_idle_line", low_cnt, 0);
        check("t5_no_ready", rdy_cnt, 0);
        check("t5_grant", grant_a, 1'b0);

        // NREQ=4, BAUD_DIV=1 on u_b
        do_reset();
        @(negedge clk);
        data_b[31:24] = 8'hFF;
        valid_b = 4'b1000;
        #1 check("t4_ready", ready_b, 4'b1000);
        @(negedge clk) valid_b = 4'b0000;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            obs10[i] = txd_b;
            if (busy_b) busy_cnt++;
            @(negedge clk);
        end
        check("t4_waveform", obs10, 10'b11_1111_1110);
        check("t4_busy_cycles", busy_cnt, 10);
        check("t4_grant", grant_b, 2'd3);
        valid_b = 4'b1111;
        #1 check("t4_wrap", ready_b, 4'b0001);
        @(negedge clk) valid_b = 4'b0000;
        repeat (12) @(negedge clk);
        check("t4_grant0", grant_b, 2'd0);

`ifdef UART_ARB_LINE_LOCK_EN
        // Line lock: "hi\n" from requester 0 while requester 1 stays valid
        begin
            logic [7:0] msg[3];
            int idx;
            int lk_on;
            msg[0] = 8'h68;
            msg[1] = 8'h69;
            msg[2] = 8'h0A;
            do_reset();
            @(negedge clk);
            idx = 0;
            data_a = {8'hB1, msg[0]};
            valid_a = 2'b11;
            n = 0;
            c = 0;
            lk_on = 0;
            while (n < 4 && c < 600) begin
                #1;
                if (locked_a && ready_a[1]) lk_on++;
                if (|(valid_a & ready_a)) begin
                    ids[n] = ready_a[1] ? 1 : 0;
                    sb.push_back(ready_a[1] ? {1'b1, 8'hB1} : {1'b0, data_a[7:0]});
                    n++;
                    @(negedge clk);
                    c++;
                    if (ids[n-1] == 0) begin
                        idx++;
                        check("t6_locked", locked_a, idx < 3);
                        if (idx < 3) data_a[7:0] = msg[idx];
                        else valid_a[0] = 1'b0;
                    end else begin
                        valid_a[1] = 1'b0;
                    end
                end else begin
                    @(negedge clk);
                    c++;
                end
            end
            valid_a = 2'b00;
            check("t6_count", n, 4);
            for (int i = 0; i < 4; i++) check("t6_order", ids[i], (i == 3) ? 1 : 0);
            check("t6_no_foreign_ready", lk_on, 0);
            wait_idle_a("t6");
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
